// File: rtl/pdm_mic_pkg.sv
// Shared constants for the PDM microphone front end: FSM encoding and PCM word width.
package pdm_mic_pkg;

   localparam int unsigned PcmWidth = 16;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StWake   = 2'd1,
      StSettle = 2'd2,
      StRun    = 2'd3
   } state_e;

endpackage

// File: rtl/pcm_fifo2.sv
// Two-entry synchronous FIFO. Shows zero when empty; drop flags a write refused
// because both entries are held and nothing is leaving this cycle.
module pcm_fifo2 #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr,
   input  logic [Width-1:0] wdata,
   input  logic             rd,
   output logic [Width-1:0] rdata,
   output logic             valid,
   output logic             drop
);

   logic [Width-1:0] mem_q [2];
   logic             rptr_q, wptr_q;
   logic [1:0]       cnt_q;
   logic             full, pop, push;

   always_comb begin
      valid = cnt_q != 2'd0;
      full  = cnt_q == 2'd2;
      pop   = valid & rd;
      // A pop frees the head slot, so a write into a full FIFO is still accepted.
      push  = wr & (~full | pop);
      drop  = wr & full & ~pop;
      rdata = valid ? mem_q[rptr_q] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         rptr_q <= 1'b0;
         wptr_q <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         if (push) wptr_q <= ~wptr_q;
         if (pop)  rptr_q <= ~rptr_q;
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/pdm_mic_ctrl.sv
// PDM microphone sequencer: bit-clock divider, data capture, CIC enable/reset,
// power-up and settle sequencing, and a 2-entry PCM output buffer.
module pdm_mic_ctrl
   import pdm_mic_pkg::*;
#(
   parameter int unsigned CLK_DIV        = 4,
   parameter int unsigned WAKE_BITS      = 1024,
   parameter int unsigned SETTLE_SAMPLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                pdm_dat,
   output logic                mic_clk,
   output logic                pdm_bit,
   output logic                cic_ce,
   output logic                cic_rst,
   input  logic [PcmWidth-1:0] pcm_in,
   input  logic                pcm_in_valid,
   output logic [PcmWidth-1:0] pcm_out,
   output logic                pcm_out_valid,
   input  logic                pcm_out_ready,
   output logic                overrun,
   output logic [1:0]          state
);

   localparam logic [8:0]  PhLast     = 9'(2 * CLK_DIV - 1);
   localparam logic [8:0]  PhHigh     = 9'(CLK_DIV);
   localparam logic [15:0] WakeLast   = 16'(WAKE_BITS - 1);
   localparam logic [7:0]  SettleLast = 8'(SETTLE_SAMPLES - 1);

   state_e      state_q, state_d;
   logic [8:0]  ph_q, ph_d;
   logic [15:0] wake_q, wake_d;
   logic [7:0]  settle_q, settle_d;
   logic [1:0]  sync_q;
   logic        mic_clk_q, pdm_bit_q, cic_ce_q, overrun_q;
   logic        mic_clk_d, pdm_bit_d, cic_ce_d, overrun_d;
   logic        capture, fifo_clr, fifo_wr, fifo_drop;

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:   state_d = StWake;
            StWake:   if (cic_ce_q && wake_q == WakeLast) state_d = StSettle;
            StSettle: begin
               if (SETTLE_SAMPLES == 0 || (pcm_in_valid && settle_q == SettleLast)) begin
                  state_d = StRun;
               end
            end
            StRun:    state_d = StRun;
         endcase
      end
   end

   always_comb begin
      cic_rst       = (state_q == StIdle) || (state_q == StWake);
      state         = state_q;
      mic_clk       = mic_clk_q;
      pdm_bit       = pdm_bit_q;
      cic_ce        = cic_ce_q;
      overrun       = overrun_q;
   end

   always_comb begin
      capture   = (state_q != StIdle) && (ph_q == PhLast);
      fifo_clr  = state_d == StIdle;
      fifo_wr   = (state_q == StRun) && pcm_in_valid;

      // The phase restarts at 0 on entry to WAKE, so the first period has no strobe.
      if (state_q == StIdle || state_d == StIdle) ph_d = '0;
      else if (ph_q == PhLast)                    ph_d = '0;
      else                                        ph_d = ph_q + 9'd1;

      wake_d = wake_q;
      if (fifo_clr)                            wake_d = '0;
      else if (state_q == StWake && cic_ce_q)  wake_d = wake_q + 16'd1;

      settle_d = settle_q;
      if (fifo_clr)                                    settle_d = '0;
      else if (state_q == StSettle && pcm_in_valid)    settle_d = settle_q + 8'd1;

      mic_clk_d = ph_d >= PhHigh;
      pdm_bit_d = capture ? sync_q[1] : pdm_bit_q;
      cic_ce_d  = capture && enable;
      overrun_d = fifo_clr ? 1'b0 : (overrun_q | fifo_drop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_q      <= '0;
         wake_q    <= '0;
         settle_q  <= '0;
         sync_q    <= '0;
         mic_clk_q <= 1'b0;
         pdm_bit_q <= 1'b0;
         cic_ce_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         ph_q      <= ph_d;
         wake_q    <= wake_d;
         settle_q  <= settle_d;
         sync_q    <= {sync_q[0], pdm_dat};
         mic_clk_q <= mic_clk_d;
         pdm_bit_q <= pdm_bit_d;
         cic_ce_q  <= cic_ce_d;
         overrun_q <= overrun_d;
      end
   end

   pcm_fifo2 #(
      .Width(PcmWidth)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .clr  (fifo_clr),
      .wr   (fifo_wr),
      .wdata(pcm_in),
      .rd   (pcm_out_ready),
      .rdata(pcm_out),
      .valid(pcm_out_valid),
      .drop (fifo_drop)
   );

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Bench for pdm_mic_ctrl: event-level reference model checked every cycle, plus
// directed sequences with literal expectations.
module tb_pdm_mic_ctrl;

   localparam int unsigned CD = 4;
   localparam int unsigned WB = 8;
   localparam int unsigned SS = 4;
   localparam int unsigned P  = 2 * CD;

   logic        clk = 1'b0;
   logic        rst, enable, pdm_dat, pcm_in_valid, pcm_out_ready;
   logic [15:0] pcm_in;
   logic        mic_clk, pdm_bit, cic_ce, cic_rst, pcm_out_valid, overrun;
   logic [15:0] pcm_out;
   logic [1:0]  state;

   int unsigned vecs = 0;
   int unsigned errs = 0;

   pdm_mic_ctrl #(
      .CLK_DIV       (CD),
      .WAKE_BITS     (WB),
      .SETTLE_SAMPLES(SS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .pdm_dat      (pdm_dat),
      .mic_clk      (mic_clk),
      .pdm_bit      (pdm_bit),
      .cic_ce       (cic_ce),
      .cic_rst      (cic_rst),
      .pcm_in       (pcm_in),
      .pcm_in_valid (pcm_in_valid),
      .pcm_out      (pcm_out),
      .pcm_out_valid(pcm_out_valid),
      .pcm_out_ready(pcm_out_ready),
      .overrun      (overrun),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs as the DUT saw them at the last rising edge.
   logic        s_rst, s_en, s_dat, s_piv, s_rdy;
   logic [15:0] s_pin;
   bit          seen = 1'b0;

   always @(posedge clk) begin
      s_rst <= rst;
      s_en  <= enable;
      s_dat <= pdm_dat;
      s_piv <= pcm_in_valid;
      s_rdy <= pcm_out_ready;
      s_pin <= pcm_in;
      seen  <= 1'b1;
   end

   // Reference model: m_n counts cycles since entering WAKE; everything derives from it.
   int unsigned m_st, m_n, m_sc;
   logic [15:0] m_q[$];
   logic        m_ovr, m_bit, h1, h2;

   task automatic model_step();
      bit act_pre;
      act_pre = m_st != 0;
      if (s_rst) begin
         m_st = 0; m_n = 0; m_sc = 0; m_q.delete();
         m_ovr = 1'b0; m_bit = 1'b0; h1 = 1'b0; h2 = 1'b0;
         return;
      end
      // Captured bit is the pad value sampled two edges before the mic_clk falling edge.
      if (act_pre && (m_n % P == P - 1)) m_bit = h2;
      h2 = h1;
      h1 = s_dat;
      if (act_pre && !s_en) begin
         m_st = 0; m_n = 0; m_sc = 0; m_q.delete(); m_ovr = 1'b0;
      end else begin
         case (m_st)
            0: if (s_en) begin m_st = 1; m_n = 0; end
            1: begin
               m_n++;
               if (m_n == P * WB + 1) m_st = 2;
            end
            2: begin
               m_n++;
               if (s_piv) begin
                  m_sc++;
                  if (m_sc == SS) m_st = 3;
               end
            end
            default: begin
               m_n++;
               if (m_q.size() != 0 && s_rdy) void'(m_q.pop_front());
               if (s_piv) begin
                  if (m_q.size() < 2) m_q.push_back(s_pin);
                  else                m_ovr = 1'b1;
               end
            end
         endcase
      end
   endtask

   always @(negedge clk) begin
      if (seen) begin
         model_step();
         chk("state", {30'd0, state}, m_st);
         chk("mic_clk", {31'd0, mic_clk}, {31'd0, (m_st != 0) && (m_n % P >= CD)});
         chk("cic_ce", {31'd0, cic_ce}, {31'd0, (m_st != 0) && (m_n > 0) && (m_n % P == 0)});
         chk("cic_rst", {31'd0, cic_rst}, {31'd0, m_st < 2});
         chk("pdm_bit", {31'd0, pdm_bit}, {31'd0, m_bit});
         chk("pcm_out_valid", {31'd0, pcm_out_valid}, {31'd0, m_q.size() != 0});
         chk("pcm_out", {16'd0, pcm_out}, {16'd0, (m_q.size() != 0) ? m_q[0] : 16'd0});
         chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      end
   end

   logic [3:0]  pat = 4'b0110;
   bit          act = 1'b0;
   int unsigned n_tb = 0;

   task automatic tick();
      @(negedge clk);
      #1;
      if (act) begin
         n_tb++;
         if (n_tb % P == CD) pdm_dat = pat[(n_tb / P) % 4];
      end
   endtask

   task automatic send(input logic [15:0] w);
      pcm_in_valid = 1'b1;
      pcm_in       = w;
      tick();
      pcm_in_valid = 1'b0;
   endtask

   int unsigned strobes;
   bit          done;

   initial begin
      rst = 1'b1; enable = 1'b0; pdm_dat = 1'b0;
      pcm_in_valid = 1'b0; pcm_in = '0; pcm_out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_state", {30'd0, state}, 0);
      chk("rst_cic_rst", {31'd0, cic_rst}, 1);
      chk("rst_mic_clk", {31'd0, mic_clk}, 0);
      chk("rst_valid", {31'd0, pcm_out_valid}, 0);
      chk("rst_pcm_out", {16'd0, pcm_out}, 0);

      // Wake: 8 strobes, mic_clk period 8, captured 0,1,1,0.
      enable = 1'b1;
      tick();
      act = 1'b1;
      n_tb = 0;
      chk("wake_state", {30'd0, state}, 1);
      strobes = 0;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (state == 2'd2) begin
            done = 1'b1;
         end else begin
            if (cic_ce) strobes++;
            if (n_tb == CD - 1) chk("mic_clk_low", {31'd0, mic_clk}, 0);
            if (n_tb == CD)     chk("mic_clk_rise", {31'd0, mic_clk}, 1);
            if (n_tb % P == 1 && n_tb >= P + 1 && n_tb <= 4 * P + 1)
               chk("pdm_bit_seq", {31'd0, pdm_bit}, {31'd0, pat[(n_tb / P) - 1]});
            tick();
         end
      end
      chk("wake_done", {31'd0, done}, 1);
      chk("settle_entry_cycle", n_tb, P * WB + 1);
      chk("wake_strobes", strobes, WB);
      chk("settle_cic_rst", {31'd0, cic_rst}, 0);

      // Settle discards 1..4; 5 and 6 come out.
      for (int w = 1; w <= 4; w++) begin
         send(16'(w));
         chk("settle_no_out", {31'd0, pcm_out_valid}, 0);
         if (w < 4) tick();
      end
      chk("run_state", {30'd0, state}, 3);
      send(16'd5);
      chk("word5", {16'd0, pcm_out}, 5);
      send(16'd6);
      chk("word6", {16'd0, pcm_out}, 6);
      tick();
      chk("drained", {31'd0, pcm_out_valid}, 0);

      // Full FIFO with simultaneous write and pop: no drop.
      pcm_out_ready = 1'b0;
      pcm_in_valid = 1'b1;
      pcm_in = 16'd100; tick();
      pcm_in = 16'd200; tick();
      chk("full_head", {16'd0, pcm_out}, 100);
      pcm_out_ready = 1'b1;
      pcm_in = 16'd300; tick();
      pcm_in_valid = 1'b0;
      chk("wp_head", {16'd0, pcm_out}, 200);
      tick();
      chk("wp_next", {16'd0, pcm_out}, 300);
      tick();
      chk("wp_empty", {31'd0, pcm_out_valid}, 0);
      chk("wp_no_overrun", {31'd0, overrun}, 0);

      // Overrun: 30 is dropped.
      pcm_out_ready = 1'b0;
      pcm_in_valid = 1'b1;
      pcm_in = 16'd10; tick();
      pcm_in = 16'd20; tick();
      pcm_in = 16'd30; tick();
      pcm_in_valid = 1'b0;
      chk("ovr_flag", {31'd0, overrun}, 1);
      chk("ovr_head", {16'd0, pcm_out}, 10);
      pcm_out_ready = 1'b1;
      tick();
      chk("ovr_second", {16'd0, pcm_out}, 20);
      tick();
      chk("ovr_empty", {31'd0, pcm_out_valid}, 0);
      chk("ovr_sticky", {31'd0, overrun}, 1);

      // Disable with two words buffered.
      pcm_out_ready = 1'b0;
      pcm_in_valid = 1'b1;
      pcm_in = 16'd40; tick();
      pcm_in = 16'd50; tick();
      pcm_in_valid = 1'b0;
      chk("buf_valid", {31'd0, pcm_out_valid}, 1);
      enable = 1'b0;
      tick();
      act = 1'b0;
      chk("off_state", {30'd0, state}, 0);
      chk("off_valid", {31'd0, pcm_out_valid}, 0);
      chk("off_mic_clk", {31'd0, mic_clk}, 0);
      chk("off_cic_rst", {31'd0, cic_rst}, 1);
      chk("off_overrun", {31'd0, overrun}, 0);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
